// File: rtl/servo_bank.sv
// servo_bank: multi-channel servo PWM generator with per-channel angle ramping; define SERVO_SWEEP_EN to add auto-sweep (sweep_en, SWEEP_MAX)
module servo_bank #(
    parameter int CH = 4,
    parameter int AW = 8,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US = 1000,
    parameter int US_PER_DEG = 6,
    parameter int MAX_ANGLE = 180,
`ifdef SERVO_SWEEP_EN
    parameter int SWEEP_MAX = 90,
`endif
    localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_us,
    input  logic          tick_ms,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_ch,
    input  logic [AW-1:0] wr_target,
    input  logic [7:0]    wr_speed,
    input  logic [3:0]    wr_step,
`ifdef SERVO_SWEEP_EN
    input  logic [CH-1:0] sweep_en,
`endif
    output logic [CH-1:0] servo_pin,
    output logic [CH-1:0] busy,
    output logic          frame_start
);
    logic [31:0]   r_cnt;
    logic          r_fs;
    logic [CH-1:0] r_pin;
    logic [CH-1:0] r_busy;
    logic [31:0]   r_lw    [CH];
    logic [AW-1:0] r_cur   [CH];
    logic [AW-1:0] r_tgt   [CH];
    logic [7:0]    r_speed [CH];
    logic [3:0]    r_step  [CH];
    logic [7:0]    r_div   [CH];
    logic          w_wrap;
    logic [AW-1:0] w_wr_tgt;
    logic [CH-1:0] w_event;
    logic [31:0]   w_diff  [CH];
    logic [31:0]   w_mv    [CH];
    logic [AW-1:0] w_next  [CH];
    logic [31:0]   w_width [CH];

    assign w_wrap      = tick_us && (r_cnt == 32'(PERIOD_US - 1));
    assign w_wr_tgt    = (wr_target > AW'(MAX_ANGLE)) ? AW'(MAX_ANGLE) : wr_target;
    assign servo_pin   = r_pin;
    assign busy        = r_busy;
    assign frame_start = r_fs;

    // per-channel ramp step (clamped to remaining distance) and pulse width from current angle
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            w_event[i] = r_div[i] == r_speed[i];
            w_diff[i]  = (r_cur[i] < r_tgt[i]) ? 32'(r_tgt[i]) - 32'(r_cur[i]) : 32'(r_cur[i]) - 32'(r_tgt[i]);
            w_mv[i]    = (32'(r_step[i]) < w_diff[i]) ? 32'(r_step[i]) : w_diff[i];
            w_next[i]  = (r_cur[i] < r_tgt[i]) ? AW'(32'(r_cur[i]) + w_mv[i]) : AW'(32'(r_cur[i]) - w_mv[i]);
            w_width[i] = 32'(MIN_US) + 32'(r_cur[i]) * 32'(US_PER_DEG);
        end
    end

    // frame counter, wrap pulse, width latch at wrap, and pins updated only on tick_us
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_fs  <= 1'b0;
            r_pin <= '0;
            for (int i = 0; i < CH; i++) r_lw[i] <= 32'(MIN_US);
        end else begin
            r_fs <= w_wrap;
            if (tick_us) begin
                r_cnt <= w_wrap ? '0 : r_cnt + 32'd1;
                for (int i = 0; i < CH; i++) begin
                    r_pin[i] <= r_cnt < r_lw[i];
                    if (w_wrap) r_lw[i] <= w_width[i];
                end
            end
        end
    end

    // ramp dividers and angle motion; a same-cycle write lands after the ramp so the ramp sees old tgt/step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            for (int i = 0; i < CH; i++) begin
                r_cur[i]   <= '0;
                r_tgt[i]   <= '0;
                r_speed[i] <= '0;
                r_step[i]  <= 4'd1;
                r_div[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                r_busy[i] <= r_cur[i] != r_tgt[i];
                if (tick_ms) begin
                    r_div[i] <= w_event[i] ? '0 : r_div[i] + 8'd1;
                    if (w_event[i]) r_cur[i] <= w_next[i];
                end
`ifdef SERVO_SWEEP_EN
                if (sweep_en[i] && r_cur[i] == r_tgt[i]) r_tgt[i] <= (r_tgt[i] == '0) ? AW'(SWEEP_MAX) : '0;
`endif
                if (wr_en && wr_ch == CW'(i)) begin
                    r_tgt[i]   <= w_wr_tgt;
                    r_speed[i] <= wr_speed;
                    r_step[i]  <= wr_step;
                    r_div[i]   <= '0;
                end
            end
        end
    end
endmodule
